// File: rtl/eth_rx_parser.sv
// eth_rx_parser
// Strips the 14-byte Ethernet header from a 64-bit frame stream, filters on
// destination MAC, and realigns the payload so its first byte lands in byte 0
// of the output bus. The header fields of the most recent accepted frame are
// exposed on hdr_*, together with wrapping good/dropped frame counters.
module eth_rx_parser #(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter bit          ACCEPT_BCAST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,

    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,

    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [15:0] hdr_ethertype,

    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        FLUSH,
        DROP
    } state_t;

    localparam logic [47:0] BCAST_MAC = 48'hffffffffffff;

    state_t      state;

    // Header bytes seen in flit 0, held until flit 1 completes the header.
    logic [47:0] dst_shadow;
    logic [15:0] src_hi_shadow;

    // Last two bytes of the previous input flit, prepended to the next one.
    // residual_two says whether both bytes are real (1) or only byte 0 (0).
    logic [15:0] residual;
    logic        residual_two;

    // Output register stage.
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic        out_valid;

    // Published header and statistics.
    logic [47:0] dst_mac_q;
    logic [47:0] src_mac_q;
    logic [15:0] ethertype_q;
    logic [15:0] ok_cnt;
    logic [15:0] drop_cnt;

    logic        in_ready;
    logic        in_fire;
    logic        out_load;
    logic        dst_match;

    // Wire byte 0 of a field is its most significant byte, so the fields are
    // byte-reversed relative to the little-endian bus lanes.
    logic [47:0] in_dst;
    logic [15:0] in_src_hi;
    logic [31:0] in_src_lo;
    logic [15:0] in_type;
    logic [15:0] hdr1_tail;
    logic [63:0] flush_data;
    logic [7:0]  flush_keep;

    assign in_dst    = {stream_in_DATA[7:0],   stream_in_DATA[15:8],
                        stream_in_DATA[23:16], stream_in_DATA[31:24],
                        stream_in_DATA[39:32], stream_in_DATA[47:40]};
    assign in_src_hi = {stream_in_DATA[55:48], stream_in_DATA[63:56]};
    assign in_src_lo = {stream_in_DATA[7:0],   stream_in_DATA[15:8],
                        stream_in_DATA[23:16], stream_in_DATA[31:24]};
    assign in_type   = {stream_in_DATA[39:32], stream_in_DATA[47:40]};

    assign dst_match = (in_dst == MAC_ADDR_FPGA) ||
                       (ACCEPT_BCAST && (in_dst == BCAST_MAC));

    // The output register may take a new flit when empty or being drained.
    assign out_load = !out_valid || stream_out_READY;
    assign in_fire  = stream_in_VALID && in_ready;

    // Payload bytes 0-1 of a frame that ends in flit 1; byte 7 is blanked when
    // only byte 6 is present.
    assign hdr1_tail  = stream_in_KEEP[7] ? stream_in_DATA[63:48]
                                          : {8'h00, stream_in_DATA[55:48]};
    assign flush_data = {48'h0, residual_two ? residual : {8'h00, residual[7:0]}};
    assign flush_keep = {6'b0, residual_two, 1'b1};

    // Input handshake: PAYLOAD is the only state that produces an output per
    // accepted flit, so it alone follows the output register's availability.
    always_comb begin
        // NOTE: default assignment first so every path drives in_ready and no latch is inferred.
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                HDR0, HDR1, DROP: in_ready = 1'b1;
                PAYLOAD:          in_ready = out_load;
                FLUSH:            in_ready = 1'b0;
                default:          in_ready = 1'b0;
            endcase
        end
    end

    // Parser FSM together with the output register, header latches and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HDR0;
            dst_shadow    <= '0;
            src_hi_shadow <= '0;
            residual      <= '0;
            residual_two  <= 1'b0;
            out_data      <= '0;
            out_keep      <= '0;
            out_last      <= 1'b0;
            out_valid     <= 1'b0;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            ethertype_q   <= '0;
            ok_cnt        <= '0;
            drop_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later lines in this block
            // that set out_valid override this default within the same edge.
            if (stream_out_READY) begin
                out_valid <= 1'b0;
            end

            case (state)
                HDR0: begin
                    if (in_fire) begin
                        if (stream_in_LAST) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end else if (dst_match) begin
                            dst_shadow    <= in_dst;
                            src_hi_shadow <= in_src_hi;
                            state         <= HDR1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                HDR1: begin
                    if (in_fire) begin
                        dst_mac_q    <= dst_shadow;
                        src_mac_q    <= {src_hi_shadow, in_src_lo};
                        ethertype_q  <= in_type;
                        residual     <= stream_in_DATA[63:48];
                        residual_two <= stream_in_KEEP[7];
                        if (!stream_in_LAST) begin
                            state <= PAYLOAD;
                        end else if (!stream_in_KEEP[6]) begin
                            // Header only, no payload at all: runt.
                            drop_cnt <= drop_cnt + 16'd1;
                            state    <= HDR0;
                        end else if (out_load) begin
                            out_data  <= {48'h0, hdr1_tail};
                            out_keep  <= {6'b0, stream_in_KEEP[7], 1'b1};
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            ok_cnt    <= ok_cnt + 16'd1;
                            state     <= HDR0;
                        end else begin
                            // Output still stalled on the previous frame; the
                            // residual is already held, so emit it from FLUSH.
                            state <= FLUSH;
                        end
                    end
                end

                PAYLOAD: begin
                    if (in_fire) begin
                        out_data  <= {stream_in_DATA[47:0], residual};
                        out_valid <= 1'b1;
                        residual  <= stream_in_DATA[63:48];
                        if (!stream_in_LAST) begin
                            out_keep <= 8'hff;
                            out_last <= 1'b0;
                        end else if (stream_in_KEEP[6]) begin
                            // More than six bytes: the last one or two spill over.
                            out_keep     <= 8'hff;
                            out_last     <= 1'b0;
                            residual_two <= stream_in_KEEP[7];
                            state        <= FLUSH;
                        end else begin
                            out_keep <= {stream_in_KEEP[5:0], 2'b11};
                            out_last <= 1'b1;
                            ok_cnt   <= ok_cnt + 16'd1;
                            state    <= HDR0;
                        end
                    end
                end

                FLUSH: begin
                    if (out_load) begin
                        out_data  <= flush_data;
                        out_keep  <= flush_keep;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        ok_cnt    <= ok_cnt + 16'd1;
                        state     <= HDR0;
                    end
                end

                DROP: begin
                    if (in_fire && stream_in_LAST) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        state    <= HDR0;
                    end
                end

                default: state <= HDR0;
            endcase
        end
    end

    assign stream_in_READY  = in_ready;
    assign stream_out_DATA  = out_data;
    assign stream_out_KEEP  = out_keep;
    assign stream_out_LAST  = out_last;
    assign stream_out_VALID = out_valid;
    assign hdr_dst_mac      = dst_mac_q;
    assign hdr_src_mac      = src_mac_q;
    assign hdr_ethertype    = ethertype_q;
    assign frames_ok        = ok_cnt;
    assign frames_dropped   = drop_cnt;

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 The block SHALL have parameter MAC_ADDR_FPGA, default 48'hfa163e55ca02, station MAC accepted as destination.
REQ-002 The block SHALL have parameter ACCEPT_BCAST, default 1, which when 1 also accepts destination 48'hffffffffffff.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have ports stream_in_DATA input 64, stream_in_KEEP input 8, stream_in_LAST input 1, stream_in_VALID input 1 and stream_in_READY output 1, forming the raw Ethernet frame stream.
REQ-006 The block SHALL have ports stream_out_DATA output 64, stream_out_KEEP output 8, stream_out_LAST output 1, stream_out_VALID output 1 and stream_out_READY input 1, forming the realigned payload stream.
REQ-007 The block SHALL have outputs hdr_dst_mac 48, hdr_src_mac 48 and hdr_ethertype 16, carrying the current frame's header fields.
REQ-008 The block SHALL have outputs frames_ok 16 and frames_dropped 16, which are wrapping counters.

Function
REQ-009 Byte order SHALL be frame byte 8k+b in flit k, bits [8b+7:8b]; KEEP is contiguous from bit 0; the first wire byte of a MAC or ethertype is its most significant byte.
REQ-010 Header mapping SHALL be: flit0 bytes 0-5 dst MAC, flit0 bytes 6-7 plus flit1 bytes 0-3 src MAC, flit1 bytes 4-5 ethertype, with payload starting at flit1 byte 6.
REQ-011 The FSM states SHALL be HDR0, HDR1, PAYLOAD, FLUSH and DROP; the reset state is HDR0.
REQ-012 HDR0 SHALL behave as follows on an accepted flit:
- dst matches MAC_ADDR_FPGA, or is broadcast with ACCEPT_BCAST=1: latch dst and src bytes 0-1, then go to HDR1.
- otherwise go to DROP.
- LAST=1 on flit0: count as a drop and stay in HDR0.
REQ-013 HDR1 SHALL latch the rest of the src MAC and the ethertype, and SHALL hold flit1 bytes 6-7 as a 2-byte residual.
- not LAST: go to PAYLOAD.
- LAST with KEEP[6]=1: emit one flit with the residual (KEEP 8'h01 or 8'h03), LAST=1, count ok, go to HDR0.
- LAST with KEEP[6]=0: runt; count a drop, no output, go to HDR0.
REQ-014 PAYLOAD SHALL, per accepted input flit, emit output DATA = {in bytes 0-5, residual bytes 0-1}, with the residual in output bytes 0-1, and then reload the residual from input bytes 6-7.
REQ-015 On PAYLOAD LAST, with n input bytes:
- n<=6: emit one flit with KEEP = (1<<(n+2))-1, LAST=1, count ok, go to HDR0.
- n>6: emit a non-last flit with KEEP 8'hff, go to FLUSH.
REQ-016 FLUSH SHALL emit the residual bytes (n-6 of them, KEEP 8'h01 or 8'h03) with LAST=1, count ok, go to HDR0, and hold stream_in_READY=0.
REQ-017 DROP SHALL hold stream_in_READY=1, produce no output, and on an accepted LAST count a drop and go to HDR0.
REQ-018 The output SHALL be a single register stage. It loads when stream_out_VALID=0 or stream_out_READY=1, and DATA, KEEP, LAST and VALID stay stable while VALID=1 and READY=0.
REQ-019 stream_in_READY SHALL be 1 in HDR0, HDR1 and DROP, 0 in FLUSH, and (!stream_out_VALID | stream_out_READY) in PAYLOAD.
REQ-020 The block SHALL add one cycle of latency: an output flit is valid the cycle after the input flit that completes it is accepted.
REQ-021 The hdr_* outputs SHALL update only when a header is fully latched and SHALL hold until the next accepted frame's HDR1.
REQ-022 Counters SHALL increment by exactly 1 per frame, at the LAST decision, and SHALL wrap 16'hffff->0.
REQ-023 No accepted input byte SHALL be lost or duplicated.

Reset
REQ-024 On rst=1 at a clock edge:
- state SHALL go to HDR0 and any partial frame SHALL be discarded.
- stream_out_VALID, LAST and KEEP SHALL be 0, and DATA SHALL be 0.
- stream_in_READY SHALL be 0 during reset and 1 the cycle after release.
- hdr_* and both counters SHALL be 0.

Verification
REQ-025 Accept with realignment:
- stimulus: flits 64'hc40c02ca553e16fa/ff; 64'h2211000847c0887a/ff; 64'haa99887766554433/ff; 64'h00000000eeddccbb/0f LAST.
- output: 64'h8877665544332211/ff, then 64'h0000eeddccbbaa99/3f LAST.
- also: hdr_src_mac=48'h0cc47a88c047, hdr_ethertype=16'h0800, frames_ok=1.
REQ-026 Flush: same frame but last flit 64'h1111111111111111/ff -> three output flits, the last being 64'h1111/03 LAST, with stream_in_READY=0 during the FLUSH cycle.
REQ-027 Filter: dst 48'h0cc47a88c047 over 4 flits -> no output, READY stays 1, frames_dropped=1; broadcast dst with ACCEPT_BCAST=1 -> accepted.
REQ-028 Runt: 2-flit frame with flit1 KEEP 8'h3f LAST -> no output, frames_dropped+1; flit1 KEEP 8'hff LAST -> one flit 64'h2211/03 LAST.
REQ-029 Backpressure:
- stimulus: stream_out_READY toggled randomly across 200 back-to-back frames.
- required: output stable while stalled, byte stream matches the reference model, frames_ok=200.
REQ-030 Reset mid-frame: rst asserted in PAYLOAD -> next cycle VALID=0 and counters=0, and the following clean frame is parsed correctly.
